// File: rtl/tank_sim_if.sv
// tank_sim_if: controller-facing lines of the tank plant emulator.
interface tank_sim_if;
   logic       m1;
   logic       drain;
   logic       bounce_en;
   logic       e1;
   logic       e2;
   logic [7:0] level;
   logic       ovf;
   modport master (output m1, drain, bounce_en, input e1, e2, level, ovf);
   modport slave  (input m1, drain, bounce_en, output e1, e2, level, ovf);
endinterface

// File: rtl/tank_sim.sv
// tank_sim: tank level plant with float-switch sensors and optional switch-bounce injection.
module tank_sim #(
   parameter int TICK_DIV   = 100,
   parameter int FILL_STEP  = 3,
   parameter int DRAIN_STEP = 1,
   parameter int LEVEL_MAX  = 255,
   parameter int LOW_MARK   = 64,
   parameter int HIGH_MARK  = 192,
   parameter int INIT_LEVEL = 128,
   parameter int BOUNCE_CYC = 20
) (
   input logic       clk,
   input logic       rst,
   tank_sim_if.slave bus
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int CW = BOUNCE_CYC > 1 ? $clog2(BOUNCE_CYC) : 1;
   localparam logic signed [9:0] LMAX = 10'(LEVEL_MAX);
   localparam logic [1:0] RAW_INIT = {1'(INIT_LEVEL < HIGH_MARK), 1'(INIT_LEVEL < LOW_MARK)};
   typedef enum logic {STABLE, BOUNCE} state_t;
   logic [PW-1:0]     r_pre;
   logic [7:0]        r_level;
   logic [7:0]        r_lfsr;
   logic              r_ovf;
   logic              w_tick;
   logic [9:0]        w_fill;
   logic [9:0]        w_drain;
   logic signed [9:0] w_sum;
   logic [7:0]        w_next;
   logic [1:0]        w_raw;
   logic [1:0]        w_e;
   assign w_tick  = r_pre == PW'(TICK_DIV - 1);
   assign w_fill  = bus.m1 ? 10'(FILL_STEP) : '0;
   assign w_drain = bus.drain ? 10'(DRAIN_STEP) : '0;
   // Modulo-1024 sum reinterpreted as signed covers -DRAIN_STEP..LEVEL_MAX+FILL_STEP.
   assign w_sum   = $signed({2'b00, r_level} + w_fill - w_drain);
   assign w_next  = w_sum < 0 ? 8'd0 : w_sum > LMAX ? LMAX[7:0] : w_sum[7:0];
   assign w_raw   = {r_level < 8'(HIGH_MARK), r_level < 8'(LOW_MARK)};
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre   <= '0;
         r_level <= 8'(INIT_LEVEL);
         r_ovf   <= 1'b0;
         r_lfsr  <= 8'hA5;
      end else begin
         r_pre  <= w_tick ? '0 : r_pre + 1'b1;
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         if (w_tick) begin
            r_level <= w_next;
            r_ovf   <= r_ovf | (bus.m1 & (w_sum > LMAX));
         end
      end
   end
   genvar i;
   generate
      for (i = 0; i < 2; i++) begin : g_snr
         state_t        r_st;
         state_t        w_st_nxt;
         logic [CW-1:0] r_cnt;
         logic [CW-1:0] w_cnt_nxt;
         logic          r_raw_q;
         logic          r_e;
         logic          w_e_nxt;
         logic          w_chg;
         assign w_chg = w_raw[i] ^ r_raw_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_st    <= STABLE;
               r_cnt   <= '0;
               r_raw_q <= RAW_INIT[i];
               r_e     <= RAW_INIT[i];
            end else begin
               r_st    <= w_st_nxt;
               r_cnt   <= w_cnt_nxt;
               r_raw_q <= w_raw[i];
               r_e     <= w_e_nxt;
            end
         end
         always_comb begin
            w_st_nxt  = !bus.bounce_en ? STABLE :
                        (w_chg || (r_st == BOUNCE && r_cnt != '0)) ? BOUNCE : STABLE;
            w_cnt_nxt = w_chg ? CW'(BOUNCE_CYC - 1) : r_cnt - 1'b1;
         end
         always_comb begin
            w_e_nxt = w_st_nxt == BOUNCE ? r_lfsr[i] : w_raw[i];
         end
         assign w_e[i] = r_e;
      end
   endgenerate
   assign bus.e1    = w_e[0];
   assign bus.e2    = w_e[1];
   assign bus.level = r_level;
   assign bus.ovf   = r_ovf;
endmodule
